// File: rtl/count_tracker.sv
// Monitor for a free-running 4-bit up-counter. It flags 15->0 rollovers, keeps a
// saturating rollover total, and latches illegal steps. A valid/ack port returns a coherent {count, total} snapshot.
module count_tracker #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A0,
  input  logic              A1,
  input  logic              A2,
  input  logic              A3,
  input  logic              clr,
  input  logic              snap_req,
  input  logic              snap_ack,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic              snap_vld,
  output logic [3:0]        snap_cnt,
  output logic [WRAP_W-1:0] snap_wraps,
  output logic              drop
);

  typedef enum logic {T_INIT, T_TRACK} trk_state_t;
  typedef enum logic {S_IDLE, S_VALID} snap_state_t;

  localparam logic [WRAP_W-1:0] WRAPS_ONE = WRAP_W'(1);

  trk_state_t  trk_st, trk_nxt;
  snap_state_t snp_st, snp_nxt;

  logic [3:0]        cur;
  logic [3:0]        prev;
  logic              roll;
  logic              bad;
  logic              capture;
  logic [WRAP_W-1:0] wraps_nxt;
  logic              err_nxt;
  logic              drop_nxt;

  assign cur = {A3, A2, A1, A0};

  // Tracker: the first edge after reset only seeds prev. After that, every edge checks the step.
  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    trk_nxt = trk_st;
    roll    = 1'b0;
    bad     = 1'b0;
    case (trk_st)
      T_INIT:  trk_nxt = T_TRACK;
      T_TRACK: begin
        roll = (prev == 4'hF) && (cur == 4'h0);
        bad  = (cur != prev) && (cur != prev + 4'd1);
      end
      default: trk_nxt = T_INIT;
    endcase
  end

  // clr beats a same-edge increment. The snapshot port also captures this post-edge value.
  always_comb begin
    wraps_nxt = wraps;
    if (clr)
      wraps_nxt = '0;
    else if (roll && (wraps != '1))
      wraps_nxt = wraps + WRAPS_ONE;
  end

  assign err_nxt  = clr ? 1'b0 : (err | bad);
  assign drop_nxt = clr ? 1'b0 : (drop | ((snp_st == S_VALID) && snap_req));

  always_comb begin
    snp_nxt = snp_st;
    capture = 1'b0;
    case (snp_st)
      S_IDLE: begin
        if (snap_req) begin
          snp_nxt = S_VALID;
          capture = 1'b1;
        end
      end
      S_VALID: begin
        if (snap_ack)
          snp_nxt = S_IDLE;
      end
      default: snp_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every right-hand side here sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_st     <= T_INIT;
      snp_st     <= S_IDLE;
      prev       <= '0;
      wrap       <= 1'b0;
      wraps      <= '0;
      err        <= 1'b0;
      drop       <= 1'b0;
      snap_cnt   <= '0;
      snap_wraps <= '0;
    end else begin
      trk_st <= trk_nxt;
      snp_st <= snp_nxt;
      prev   <= cur;
      wrap   <= roll;
      wraps  <= wraps_nxt;
      err    <= err_nxt;
      drop   <= drop_nxt;
      if (capture) begin
        snap_cnt   <= cur;
        snap_wraps <= wraps_nxt;
      end
    end
  end

  assign snap_vld = (snp_st == S_VALID);

endmodule

// File: tb/tb_count_tracker.sv
// Scoreboard bench for count_tracker. It runs an 8-bit and a 2-bit instance from the same stimulus.
// A behavioural model queues the expected outputs for each edge, and the queue is checked after that edge.
module tb_count_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'h0;
  logic       clr = 1'b0;
  logic       snap_req = 1'b0;
  logic       snap_ack = 1'b0;

  logic       wrap8, err8, vld8, drop8;
  logic [7:0] wraps8, sw8;
  logic [3:0] scnt8;
  logic       wrap2, err2, vld2, drop2;
  logic [1:0] wraps2, sw2;
  logic [3:0] scnt2;

  count_tracker #(.WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .clr(clr), .snap_req(snap_req), .snap_ack(snap_ack),
    .wrap(wrap8), .wraps(wraps8), .err(err8), .snap_vld(vld8),
    .snap_cnt(scnt8), .snap_wraps(sw8), .drop(drop8)
  );

  count_tracker #(.WRAP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .clr(clr), .snap_req(snap_req), .snap_ack(snap_ack),
    .wrap(wrap2), .wraps(wraps2), .err(err2), .snap_vld(vld2),
    .snap_cnt(scnt2), .snap_wraps(sw2), .drop(drop2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wrap, w8, w2, err, vld, scnt, sw8, sw2, drop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state
  int m_init, m_prev, m_wrap, m_w8, m_w2, m_err, m_vld, m_scnt, m_sw8, m_sw2, m_drop;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_prev = 0; m_wrap = 0; m_w8 = 0; m_w2 = 0; m_err = 0;
    m_vld = 0; m_scnt = 0; m_sw8 = 0; m_sw2 = 0; m_drop = 0;
  endtask

  task automatic model_edge(input int cur, input bit c, input bit rq, input bit ak);
    bit roll, bad;
    roll = !m_init && (m_prev == 15) && (cur == 0);
    bad  = !m_init && (cur != m_prev) && (cur != ((m_prev + 1) % 16));
    if (c) begin
      m_w8 = 0; m_w2 = 0; m_err = 0;
    end else begin
      if (roll && m_w8 < 255) m_w8++;
      if (roll && m_w2 < 3)   m_w2++;
      if (bad) m_err = 1;
    end
    if (c) m_drop = 0;
    else if (m_vld && rq) m_drop = 1;
    if (!m_vld) begin
      if (rq) begin
        m_vld = 1; m_scnt = cur; m_sw8 = m_w8; m_sw2 = m_w2;
      end
    end else if (ak) begin
      m_vld = 0;
    end
    m_wrap = roll;
    m_prev = cur;
    m_init = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.wrap = m_wrap; e.w8 = m_w8; e.w2 = m_w2; e.err = m_err; e.vld = m_vld;
    e.scnt = m_scnt; e.sw8 = m_sw8; e.sw2 = m_sw2; e.drop = m_drop;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".wrap"},       int'(wrap8),  e.wrap);
    check({tag, ".wraps"},      int'(wraps8), e.w8);
    check({tag, ".wraps_sat"},  int'(wraps2), e.w2);
    check({tag, ".err"},        int'(err8),   e.err);
    check({tag, ".snap_vld"},   int'(vld8),   e.vld);
    check({tag, ".snap_cnt"},   int'(scnt8),  e.scnt);
    check({tag, ".snap_wraps"}, int'(sw8),    e.sw8);
    check({tag, ".snap_wsat"},  int'(sw2),    e.sw2);
    check({tag, ".drop"},       int'(drop8),  e.drop);
    check({tag, ".sat_wrap"},   int'(wrap2),  e.wrap);
  endtask

  task automatic cycle(input int v, input bit c, input bit rq, input bit ak, input string tag);
    a = v[3:0]; clr = c; snap_req = rq; snap_ack = ak;
    model_edge(v, c, rq, ak);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic hard_reset(input int v, input int hold);
    rst = 1'b0; a = v[3:0]; clr = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
    #1;
    model_reset();
    sb.push_back(model_out());
    compare("rst_async");
    repeat (hold) @(posedge clk);
    #1;
    sb.push_back(model_out());
    compare("rst_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int v;
    #2;
    hard_reset(5, 2);
    cycle(5, 0, 0, 0, "seed_nonzero");

    hard_reset(0, 1);
    for (int i = 0; i < 40; i++) cycle(i % 16, 0, 0, 0, "free_run");
    check("free_run_total", int'(wraps8), 2);

    v = 7;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 != 2) v = (v + 1) % 16;
      cycle(v, 0, 0, 0, "holds");
    end

    cycle(3, 0, 0, 0, "illegal_3");
    cycle(7, 0, 0, 0, "illegal_7");
    cycle(8, 0, 0, 0, "sticky_8");
    cycle(9, 0, 0, 0, "sticky_9");
    cycle(10, 1, 0, 0, "clr_err");
    cycle(11, 0, 0, 0, "after_clr");
    v = 11;

    for (int i = 0; i < 90; i++) begin
      v = (v + 1) % 16;
      cycle(v, 0, 0, 0, "saturate");
    end
    check("sat_total", int'(wraps2), 3);
    while (v != 15) begin
      v++;
      cycle(v, 0, 0, 0, "to_15");
    end
    cycle(0, 1, 0, 0, "clr_on_roll");
    check("clr_on_roll_pulse", int'(wrap8), 1);

    for (int i = 1; i < 16; i++) cycle(i, 0, 0, 0, "to_roll");
    cycle(0, 0, 0, 0, "roll_once");
    for (int i = 1; i < 9; i++) cycle(i, 0, 0, 0, "to_9");
    cycle(9, 0, 1, 0, "snap_req");
    cycle(10, 0, 0, 0, "snap_hold");
    cycle(11, 0, 0, 0, "snap_hold");
    cycle(12, 0, 1, 0, "snap_drop");
    cycle(13, 0, 0, 0, "snap_hold");
    cycle(14, 0, 0, 1, "snap_ack");
    cycle(15, 0, 0, 1, "ack_idle");
    cycle(0, 0, 1, 0, "snap_on_roll");
    cycle(1, 1, 0, 0, "clr_drop");
    cycle(2, 0, 1, 1, "req_on_ack");
    cycle(3, 0, 1, 0, "snap_again");

    hard_reset(4, 1);
    cycle(4, 0, 0, 0, "reseed");
    cycle(5, 0, 1, 0, "snap_post_rst");
    cycle(6, 0, 0, 1, "ack_post_rst");
    cycle(7, 0, 0, 0, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
